// File: rtl/led_pkg.sv
// Shared types and constants for the LED divider scheduler and its table.
package led_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    NEXT  = 2'd3
  } sched_state_t;

  localparam int LED_DIV_W = 12;
endpackage

// File: rtl/led_div_table.sv
// Slot table of {divider, dwell} pairs: one synchronous write port, one
// combinational read port addressed by the scheduler's current index.
module led_div_table #(
  parameter  int DIV_W   = 12,
  parameter  int N_SLOTS = 8,
  parameter  int DWELL_W = 8,
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [DIV_W-1:0]   wdiv_i,
  input  logic [DWELL_W-1:0] wdwell_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [DIV_W-1:0]   rdiv_o,
  output logic [DWELL_W-1:0] rdwell_o
);
  logic [DIV_W-1:0]   div_q   [N_SLOTS];
  logic [DIV_W-1:0]   div_d   [N_SLOTS];
  logic [DWELL_W-1:0] dwell_q [N_SLOTS];
  logic [DWELL_W-1:0] dwell_d [N_SLOTS];

  always_comb begin
    div_d   = div_q;
    dwell_d = dwell_q;
    if (we_i) begin
      div_d[waddr_i]   = wdiv_i;
      dwell_d[waddr_i] = wdwell_i;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '{default: '0};
      dwell_q <= '{default: '0};
    end else begin
      div_q   <= div_d;
      dwell_q <= dwell_d;
    end
  end

  assign rdiv_o   = div_q[raddr_i];
  assign rdwell_o = dwell_q[raddr_i];
endmodule

// File: rtl/led_div_sched.sv
// Drives the led_cnt div/wren port: walks a slot table with per-slot dwell
// counted in led_int edges, and interleaves one-shot override writes.
module led_div_sched
  import led_pkg::*;
#(
  parameter  int DIV_W   = LED_DIV_W,
  parameter  int N_SLOTS = 8,
  parameter  int DWELL_W = 8,
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic               enable_i,
  input  logic [IDX_W:0]     len_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_addr_i,
  input  logic [DIV_W-1:0]   cfg_div_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic               ovr_req_i,
  input  logic [DIV_W-1:0]   ovr_div_i,
  output logic               ovr_ack_o,
  input  logic               led_int_i,
  output logic [DIV_W-1:0]   div_o,
  output logic               wren_o,
  output logic [IDX_W-1:0]   slot_o,
  output logic               busy_o,
  output sched_state_t       state_o
);
  localparam logic [IDX_W:0] NS_W = (IDX_W+1)'(N_SLOTS);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               led_int_q, rise_q, rise_d;
  logic               hold_q, hold_d;
  logic               last_ovr_q, last_ovr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               wren_q, wren_d;
  logic               ack_q, ack_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic               busy_q, busy_d;

  logic [DIV_W-1:0]   tbl_div;
  logic [DWELL_W-1:0] tbl_dwell;
  logic [IDX_W:0]     len_eff, idx_inc;
  logic [DWELL_W:0]   cnt_inc, dwell_eff;
  logic               load_pend, ovr_fire, load_fire, edge_now;

  led_div_table #(.DIV_W(DIV_W), .N_SLOTS(N_SLOTS), .DWELL_W(DWELL_W)) u_table (
    .clk100   (clk100),
    .rstn     (rstn),
    .we_i     (cfg_we_i),
    .waddr_i  (cfg_addr_i),
    .wdiv_i   (cfg_div_i),
    .wdwell_i (cfg_dwell_i),
    .raddr_i  (idx_q),
    .rdiv_o   (tbl_div),
    .rdwell_o (tbl_dwell)
  );

  always_comb begin
    if (len_i == '0)       len_eff = (IDX_W+1)'(1);
    else if (len_i > NS_W) len_eff = NS_W;
    else                   len_eff = len_i;
  end

  assign idx_inc   = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign cnt_inc   = {1'b0, dwell_cnt_q} + (DWELL_W+1)'(1);
  assign dwell_eff = (tbl_dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, tbl_dwell};
  assign rise_d    = led_int_i & ~led_int_q;
  assign edge_now  = rise_q | hold_q;

  // Override handshake: ovr_req_i is a level held by the requester until the
  // single-cycle ovr_ack_o, which coincides with the override's wren_o pulse.
  // No write issues while wren_q is high; after an override, a pending LOAD
  // wins the next free slot so a held request cannot starve the sequence.
  assign load_pend = (state_q == LOAD) && enable_i;
  assign ovr_fire  = ovr_req_i && !wren_q && !(load_pend && last_ovr_q);
  assign load_fire = load_pend && !wren_q && !ovr_fire;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    hold_d      = hold_q;
    if (!enable_i) begin
      state_d = IDLE;
      hold_d  = 1'b0;
    end else if (ovr_fire) begin
      // FSM pauses; an edge arriving now is carried into the next cycle
      if (state_q == DWELL && rise_q) hold_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD;
          idx_d   = '0;
        end
        LOAD: begin
          if (load_fire) begin
            state_d     = DWELL;
            dwell_cnt_d = '0;
            hold_d      = 1'b0;
          end
        end
        DWELL: begin
          if (edge_now) begin
            hold_d = 1'b0;
            if (cnt_inc >= dwell_eff) state_d = NEXT;
            else                      dwell_cnt_d = cnt_inc[DWELL_W-1:0];
          end
        end
        NEXT: begin
          state_d = LOAD;
          idx_d   = (idx_inc >= len_eff) ? '0 : idx_inc[IDX_W-1:0];
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    div_d      = div_q;
    wren_d     = 1'b0;
    ack_d      = 1'b0;
    slot_d     = slot_q;
    last_ovr_d = last_ovr_q;
    busy_d     = (state_d != IDLE);
    if (ovr_fire) begin
      div_d      = ovr_div_i;
      wren_d     = 1'b1;
      ack_d      = 1'b1;
      last_ovr_d = 1'b1;
    end else if (load_fire) begin
      div_d      = tbl_div;
      wren_d     = 1'b1;
      slot_d     = idx_q;
      last_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      led_int_q   <= 1'b0;
      rise_q      <= 1'b0;
      hold_q      <= 1'b0;
      last_ovr_q  <= 1'b0;
      div_q       <= '0;
      wren_q      <= 1'b0;
      ack_q       <= 1'b0;
      slot_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      led_int_q   <= led_int_i;
      rise_q      <= rise_d;
      hold_q      <= hold_d;
      last_ovr_q  <= last_ovr_d;
      div_q       <= div_d;
      wren_q      <= wren_d;
      ack_q       <= ack_d;
      slot_q      <= slot_d;
      busy_q      <= busy_d;
    end
  end

  assign div_o     = div_q;
  assign wren_o    = wren_q;
  assign ovr_ack_o = ack_q;
  assign slot_o    = slot_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;
endmodule
